uart_rx: RTL and testbench

- 8N1 UART receiver, LSB first; the receive-side partner of the capitalizer's transmitter.
- Synchronizes the asynchronous serial line and detects start bits with glitch rejection.
- Samples each bit at its midpoint and delivers each byte through a one-entry valid/ready output register.
- Sits between the chip input pad and the capitalizer datapath, and flags framing and overrun errors.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/uart_rx.sv | 160 ++++++++++++++++
 tb/tb_uart_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame constants, FSM encodings
// and the bit-period helper used to size the sampling counter.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so idle-high lines come out of reset in their idle state.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with start-bit glitch rejection, a
// one-entry valid/ready output register, and framing/overrun error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 10000000,
    parameter int BAUD     = 9600
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 deliver;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_in (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_in),
        .o_q   (rx_s)
    );

    // Frame sequencing: the counter runs down to zero at each sample point.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d[idx_q] = rx_s;
                    cnt_d          = CNT_FULL;
                    idx_d          = idx_q + IDX_ONE;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // A delivery fits if the register is empty or being drained this cycle.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || i_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 1 MHz / 100 kbaud (10 clocks per bit): directed frames,
// expected events queued by the stimulus and matched by an independent monitor.
module tb_uart_rx;

    typedef enum int { EV_ACC, EV_FE, EV_OVR } ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_in = 1'b1;
    logic       i_ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;

    int  checks = 0;
    int  errors = 0;
    ev_t exp_q[$];

    uart_rx #(
        .CLK_FREQ (1000000),
        .BAUD     (100000)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_in        (i_in),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input ev_kind_t kind, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic got_ev(input ev_kind_t kind, input logic [7:0] data);
        ev_t e;
        checks++;
        $display("event %s data=0x%02h at %0t", kind.name(), data, $time);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s data=0x%02h, expected none", kind.name(), data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_ACC && e.data != data)) begin
                errors++;
                $display("FAIL event_match: got %s data=0x%02h, expected %s data=0x%02h",
                         kind.name(), data, e.kind.name(), e.data);
            end
        end
    endtask

    // Monitor: sampled mid-cycle, so values are those seen at the next rising edge.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_valid && i_ready) got_ev(EV_ACC, o_data);
            if (o_frame_err)        got_ev(EV_FE, 8'h00);
            if (o_overrun)          got_ev(EV_OVR, 8'h00);
        end
    end

    task automatic send_frame(input logic [7:0] b, input int bit_t, input logic stop_val);
        @(posedge i_clk);
        #2;
        i_in = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            i_in = b[i];
            #(bit_t);
        end
        i_in = stop_val;
        #(bit_t);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic drain(input string name);
        idle(30);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_valid", {31'd0, o_valid}, 0);
        check("rst_data", {24'd0, o_data}, 0);
        check("rst_ferr", {31'd0, o_frame_err}, 0);
        check("rst_ovr", {31'd0, o_overrun}, 0);
        i_rst = 1'b0;
        idle(5);

        // 1: ideal frames with the consumer always ready
        expect_ev(EV_ACC, 8'h61);
        send_frame(8'h61, 100, 1'b1);
        idle(5);
        check("t1_valid_drop", {31'd0, o_valid}, 0);
        expect_ev(EV_ACC, 8'h00);
        send_frame(8'h00, 100, 1'b1);
        idle(5);
        expect_ev(EV_ACC, 8'hFF);
        send_frame(8'hFF, 100, 1'b1);
        drain("t1_drain");

        // 2: short low glitch is rejected, then a real frame
        @(posedge i_clk);
        #2;
        i_in = 1'b0;
        idle(3);
        i_in = 1'b1;
        idle(30);
        check("t2_glitch_quiet", exp_q.size(), 0);
        expect_ev(EV_ACC, 8'h41);
        send_frame(8'h41, 100, 1'b1);
        drain("t2_drain");

        // 3: stop bit low followed by a held break
        expect_ev(EV_FE, 8'h00);
        send_frame(8'h55, 100, 1'b0);
        #400;
        i_in = 1'b1;
        idle(10);
        check("t3_no_valid", {31'd0, o_valid}, 0);
        expect_ev(EV_ACC, 8'h5A);
        send_frame(8'h5A, 100, 1'b1);
        drain("t3_drain");

        // 4: back-to-back frames with the consumer stalled
        i_ready = 1'b0;
        expect_ev(EV_OVR, 8'h00);
        send_frame(8'h31, 100, 1'b1);
        send_frame(8'h32, 100, 1'b1);
        idle(20);
        check("t4_valid_held", {31'd0, o_valid}, 1);
        check("t4_data_held", {24'd0, o_data}, 32'h31);
        expect_ev(EV_ACC, 8'h31);
        i_ready = 1'b1;
        idle(2);
        check("t4_valid_drop", {31'd0, o_valid}, 0);
        drain("t4_drain");

        // 5: consumer accepts exactly on the cycle the next byte lands
        i_ready = 1'b0;
        send_frame(8'h61, 100, 1'b1);
        idle(5);
        check("t5_pending", {24'd0, o_data}, 32'h61);
        expect_ev(EV_ACC, 8'h61);
        fork
            send_frame(8'h62, 100, 1'b1);
            begin
                repeat (98) @(posedge i_clk);
                #2;
                i_ready = 1'b1;
                @(posedge i_clk);
                #2;
                i_ready = 1'b0;
            end
        join
        idle(5);
        check("t5_valid_stays", {31'd0, o_valid}, 1);
        check("t5_data_new", {24'd0, o_data}, 32'h62);
        check("t5_no_overrun", exp_q.size(), 0);
        expect_ev(EV_ACC, 8'h62);
        i_ready = 1'b1;
        drain("t5_drain");

        // 6: reset during data bit 4, then fresh frames at nominal and +-4% rates
        fork
            send_frame(8'hF5, 100, 1'b1);
            begin
                repeat (56) @(posedge i_clk);
                #2;
                i_rst = 1'b1;
                #3;
                check("t6_rst_valid", {31'd0, o_valid}, 0);
                check("t6_rst_data", {24'd0, o_data}, 0);
                check("t6_rst_pulses", {30'd0, o_frame_err, o_overrun}, 0);
                #20;
                i_rst = 1'b0;
            end
        join
        drain("t6_abort_quiet");
        expect_ev(EV_ACC, 8'h7A);
        send_frame(8'h7A, 100, 1'b1);
        idle(5);
        expect_ev(EV_ACC, 8'h7A);
        send_frame(8'h7A, 96, 1'b1);
        idle(5);
        expect_ev(EV_ACC, 8'h7A);
        send_frame(8'h7A, 104, 1'b1);
        drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
